// File: rtl/enc8to3_registered_pkg.sv
// Shared definitions for the registered 8-to-3 encoder.
//   ENC_IN_W    : width of the one-hot input vector
//   ENC_OUT_W   : width of the binary index
//   prio_index(): index of the winning set bit. msb=1 picks the highest
//                 set bit, msb=0 picks the lowest. Returns 0 for all-zero.
package enc_pkg;

  localparam int ENC_IN_W  = 8;
  localparam int ENC_OUT_W = $clog2(ENC_IN_W);

  // Later assignments override earlier ones, so the scan direction decides
  // which set bit wins.
  function automatic logic [ENC_OUT_W-1:0] prio_index(
    input logic [ENC_IN_W-1:0] v,
    input logic                msb
  );
    logic [ENC_OUT_W-1:0] idx;
    idx = '0;
    if (msb) begin
      for (int i = 0; i < ENC_IN_W; i++)
        if (v[i]) idx = ENC_OUT_W'(i);
    end else begin
      for (int i = ENC_IN_W - 1; i >= 0; i--)
        if (v[i]) idx = ENC_OUT_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/enc8to3_registered_onehot_check.sv
// Combinational one-hot classifier.
//   v        : input vector
//   is_zero  : no bit of v is set
//   is_multi : two or more bits of v are set
module onehot_check
  import enc_pkg::*;
(
  input  logic [ENC_IN_W-1:0] v,
  output logic                is_zero,
  output logic                is_multi
);

  // Subtracting one clears the lowest set bit, so any bit that survives
  // the AND means a second bit was set.
  assign is_zero  = (v == '0);
  assign is_multi = ((v & (v - ENC_IN_W'(1))) != '0);

endmodule

// File: rtl/enc8to3_registered.sv
// Registered 8-to-3 binary encoder with one-hot error flags.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_vld    : qualifies inpt on the rising clock edge
//   inpt      : one-hot input vector
//   outpt     : registered binary index of the winning bit
//   out_vld   : registered copy of in_vld
//   zero_err  : registered, sampled input was all-zero
//   multi_err : registered, sampled input had more than one bit set
// Parameter PRIORITY_MSB selects highest (1) or lowest (0) set bit on
// multi-hot inputs.
module enc8to3_registered
  import enc_pkg::*;
#(
  parameter bit PRIORITY_MSB = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_vld,
  input  logic [ENC_IN_W-1:0]  inpt,
  output logic [ENC_OUT_W-1:0] outpt,
  output logic                 out_vld,
  output logic                 zero_err,
  output logic                 multi_err
);

  logic                 is_zero;
  logic                 is_multi;
  logic [ENC_OUT_W-1:0] idx;

  onehot_check u_check (
    .v        (inpt),
    .is_zero  (is_zero),
    .is_multi (is_multi)
  );

  assign idx = prio_index(inpt, PRIORITY_MSB);

  // Result and flags only update on a qualified input so that idle cycles
  // leave the last captured result visible; out_vld follows in_vld.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outpt     <= '0;
      out_vld   <= 1'b0;
      zero_err  <= 1'b0;
      multi_err <= 1'b0;
    end else if (in_vld) begin
      outpt     <= idx;
      out_vld   <= 1'b1;
      zero_err  <= is_zero;
      multi_err <= is_multi;
    end else begin
      out_vld   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_enc8to3_registered.sv
// Testbench for enc8to3_registered. Two instances share the stimulus, one
// per multi-hot priority setting. Expected results are queued at issue
// time and consumed by a monitor whenever out_vld is seen.
module tb_enc8to3_registered;

  typedef struct {
    logic [7:0] d;
    logic [2:0] om;
    logic [2:0] ol;
    logic       z;
    logic       m;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       in_vld;
  logic [7:0] inpt;
  logic [2:0] outpt_m, outpt_l;
  logic       out_vld_m, out_vld_l;
  logic       zero_err_m, zero_err_l;
  logic       multi_err_m, multi_err_l;

  int   errors = 0;
  int   checks = 0;
  vec_t sb_q[$];

  enc8to3_registered #(.PRIORITY_MSB(1'b1)) dut_msb (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld    (in_vld),
    .inpt      (inpt),
    .outpt     (outpt_m),
    .out_vld   (out_vld_m),
    .zero_err  (zero_err_m),
    .multi_err (multi_err_m)
  );

  enc8to3_registered #(.PRIORITY_MSB(1'b0)) dut_lsb (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld    (in_vld),
    .inpt      (inpt),
    .outpt     (outpt_l),
    .out_vld   (out_vld_l),
    .zero_err  (zero_err_l),
    .multi_err (multi_err_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Qualified inputs must never carry X.
  always @(posedge clk)
    if (in_vld) assert (!$isunknown(inpt)) else $error("[TB] X on inpt while in_vld=1");

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of input just after a rising edge; qualified vectors
  // queue their hand-computed expected result.
  task automatic applyStimulus(input logic vld, input vec_t v);
    @(posedge clk);
    #1;
    in_vld = vld;
    inpt   = v.d;
    if (vld) sb_q.push_back(v);
  endtask

  // Direct check of both instances for states the monitor does not see
  // (reset, idle hold).
  task automatic checkOutput(input string name, input logic [2:0] om, input logic [2:0] ol,
                             input logic vld, input logic z, input logic m);
    cmp({name, ".outpt_msb"}, 8'(outpt_m), 8'(om));
    cmp({name, ".outpt_lsb"}, 8'(outpt_l), 8'(ol));
    cmp({name, ".out_vld_msb"}, 8'(out_vld_m), 8'(vld));
    cmp({name, ".out_vld_lsb"}, 8'(out_vld_l), 8'(vld));
    cmp({name, ".zero_err"}, 8'({zero_err_m, zero_err_l}), 8'({z, z}));
    cmp({name, ".multi_err"}, 8'({multi_err_m, multi_err_l}), 8'({m, m}));
  endtask

  // Monitor: every presented result consumes one scoreboard entry.
  always @(negedge clk) begin
    if (out_vld_m || out_vld_l) begin
      if (sb_q.size() == 0) begin
        errors++;
        checks++;
        $display("[TB] FAIL sb_empty: out_vld=%b/%b with no expected entry", out_vld_m, out_vld_l);
      end else begin
        vec_t e;
        e = sb_q.pop_front();
        cmp("mon.out_vld", 8'({out_vld_m, out_vld_l}), 8'b11);
        cmp("mon.outpt_msb", 8'(outpt_m), 8'(e.om));
        cmp("mon.outpt_lsb", 8'(outpt_l), 8'(e.ol));
        cmp("mon.zero_err", 8'({zero_err_m, zero_err_l}), 8'({e.z, e.z}));
        cmp("mon.multi_err", 8'({multi_err_m, multi_err_l}), 8'({e.m, e.m}));
      end
    end
  end

  // Directed vectors: data, msb-priority index, lsb-priority index, zero, multi.
  vec_t vecs[] = '{
    '{8'h01, 3'd0, 3'd0, 1'b0, 1'b0},
    '{8'h02, 3'd1, 3'd1, 1'b0, 1'b0},
    '{8'h04, 3'd2, 3'd2, 1'b0, 1'b0},
    '{8'h08, 3'd3, 3'd3, 1'b0, 1'b0},
    '{8'h10, 3'd4, 3'd4, 1'b0, 1'b0},
    '{8'h20, 3'd5, 3'd5, 1'b0, 1'b0},
    '{8'h40, 3'd6, 3'd6, 1'b0, 1'b0},
    '{8'h80, 3'd7, 3'd7, 1'b0, 1'b0},
    '{8'h00, 3'd0, 3'd0, 1'b1, 1'b0},
    '{8'h92, 3'd7, 3'd1, 1'b0, 1'b1},
    '{8'hFF, 3'd7, 3'd0, 1'b0, 1'b1},
    '{8'h18, 3'd4, 3'd3, 1'b0, 1'b1},
    '{8'h00, 3'd0, 3'd0, 1'b1, 1'b0},
    '{8'h40, 3'd6, 3'd6, 1'b0, 1'b0}
  };

  vec_t idle_v  = '{8'h01, 3'd0, 3'd0, 1'b0, 1'b0};
  vec_t v20     = '{8'h20, 3'd5, 3'd5, 1'b0, 1'b0};
  vec_t v80     = '{8'h80, 3'd7, 3'd7, 1'b0, 1'b0};
  vec_t v04     = '{8'h04, 3'd2, 3'd2, 1'b0, 1'b0};
  vec_t v00idle = '{8'h00, 3'd0, 3'd0, 1'b0, 1'b0};

  initial begin
    rst_n  = 1'b0;
    in_vld = 1'b0;
    inpt   = 8'h00;
    #2;
    checkOutput("reset", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) applyStimulus(1'b1, vecs[i]);

    // Hold: capture 0x20, then three idle cycles with a different inpt.
    applyStimulus(1'b1, v20);
    applyStimulus(1'b0, idle_v);
    applyStimulus(1'b0, idle_v);
    checkOutput("hold1", 3'd5, 3'd5, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, idle_v);
    checkOutput("hold2", 3'd5, 3'd5, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("hold3", 3'd5, 3'd5, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset after a valid capture of 0x80, between edges.
    applyStimulus(1'b1, v80);
    applyStimulus(1'b0, v00idle);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // First capture after reset release.
    applyStimulus(1'b1, v04);
    applyStimulus(1'b0, v00idle);
    repeat (3) @(posedge clk);
    #1;
    cmp("sb_drained", 8'(sb_q.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
